// File: rtl/mcu_rstgen_const_pkg.sv
// Purpose : shared constants for the mcu_rstgen reset generator (state codes,
//           cause bit positions, cause reset value, cause-vector helper).
// Latency : n/a (declarations only).  Backpressure: n/a.
package mcu_rstgen_const_pkg;

  // Controller states. PLLW is only reachable when the PLL-wait option is built.
  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_RUN  = 2'b01,
    ST_PLLW = 2'b10
  } state_t;

  // Bit positions inside RESET_CAUSE.
  localparam int CAUSE_SYS    = 0;
  localparam int CAUSE_WDOG   = 1;
  localparam int CAUSE_LOCKUP = 2;
  localparam int CAUSE_POR    = 3;

  // RESET_CAUSE value forced while PORESET is high.
  localparam logic [3:0] CAUSE_RST_VAL = 4'b1000;

  // Packs the three warm-reset sources into cause-register bit order.
  // The power-on bit is never set from here; it only comes from reset.
  function automatic logic [3:0] cause_vec(input logic sys,
                                           input logic wdog,
                                           input logic lockup);
    logic [3:0] v;
    v               = 4'b0000;
    v[CAUSE_SYS]    = sys;
    v[CAUSE_WDOG]   = wdog;
    v[CAUSE_LOCKUP] = lockup;
    return v;
  endfunction

endpackage

// File: rtl/mcu_rstgen_stretch.sv
// Purpose : loadable/clearable up-counter with terminal-count compare, used for
//           both the reset hold stretch and the PLL lock timeout.
// Latency : count updates 1 cycle after clr/en; tc is combinational on cnt_q.
// Backpressure: none.
// Ports   : clk, rst (sync, active high), clr (force 0), en (increment),
//           term (terminal value), tc (cnt == term).
module mcu_rstgen_stretch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority over increment so a restart never advances the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/mcu_rstgen.sv
// Purpose : system reset generator; merges SYSRESETREQ, WDOGRESETREQ and
//           qualified LOCKUP into a stretched, registered active-low HRESETn.
// Latency : reset request sampled in RUN drives HRESETn low on the next edge;
//           release after RESET_CYCLES consecutive quiet cycles.
// Backpressure: none; requests are levels and simply extend the hold.
// Ports   : FCLK clock; PORESET sync active-high power-on reset; SYSRESETREQ,
//           WDOGRESETREQ, LOCKUP/LOCKUPRESET request inputs; PLL_LOCK; CAUSE_CLR
//           clear pulse; HRESETn, RESET_CAUSE, WARM_RESET_CNT, PLL_TIMEOUT_FLAG.
// Option  : define MCU_RSTGEN_PLLWAIT_EN to hold reset after the stretch until
//           PLL_LOCK or PLL_TIMEOUT cycles elapse. Without it PLL_LOCK is
//           ignored and PLL_TIMEOUT_FLAG is tied low.
module mcu_rstgen
  import mcu_rstgen_const_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int CNT_W        = 8,
  parameter int PLL_TIMEOUT  = 1024
) (
  input  logic       FCLK,
  input  logic       PORESET,
  input  logic       SYSRESETREQ,
  input  logic       WDOGRESETREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUPRESET,
  input  logic       PLL_LOCK,
  input  logic       CAUSE_CLR,
  output logic       HRESETn,
  output logic [3:0] RESET_CAUSE,
  output logic [7:0] WARM_RESET_CNT,
  output logic       PLL_TIMEOUT_FLAG
);

  // The PLL timeout needs more range than the hold stretch, so the shared
  // counter widens when the wait option is built.
`ifdef MCU_RSTGEN_PLLWAIT_EN
  localparam int CW = CNT_W + 4;
`else
  localparam int CW = CNT_W;
  localparam int unused_pll_timeout = PLL_TIMEOUT;
  logic unused_pll_lock;
  assign unused_pll_lock = PLL_LOCK;
`endif

  state_t     state_q, state_d;
  logic       hresetn_q, hresetn_d;
  logic [3:0] cause_q, cause_d;
  logic [7:0] warm_q, warm_d;

  logic          rst_evt;
  logic          lockup_req;
  logic [3:0]    cause_set;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;
  logic [CW-1:0] cnt_term;
  logic          pll_to;

  assign lockup_req = LOCKUP & LOCKUPRESET;
  assign rst_evt    = SYSRESETREQ | WDOGRESETREQ | lockup_req;
  assign cause_set  = cause_vec(SYSRESETREQ, WDOGRESETREQ, lockup_req);

`ifdef MCU_RSTGEN_PLLWAIT_EN
  assign cnt_term = (state_q == ST_PLLW) ? CW'(PLL_TIMEOUT - 1)
                                         : CW'(RESET_CYCLES - 1);
`else
  assign cnt_term = CW'(RESET_CYCLES - 1);
`endif

  mcu_rstgen_stretch #(
    .W (CW)
  ) u_stretch (
    .clk  (FCLK),
    .rst  (PORESET),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  // ---------------------------------------------------------------------------
  // State register (also holds all registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge FCLK) begin
    if (PORESET) begin
      state_q   <= ST_HOLD;
      hresetn_q <= 1'b0;
      cause_q   <= CAUSE_RST_VAL;
      warm_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      hresetn_q <= hresetn_d;
      cause_q   <= cause_d;
      warm_q    <= warm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including counter control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    pll_to  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        // Any active request restarts the stretch, so release needs a full
        // run of quiet cycles.
        if (rst_evt) begin
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
`ifdef MCU_RSTGEN_PLLWAIT_EN
          state_d = ST_PLLW;
`else
          state_d = ST_RUN;
`endif
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (rst_evt) begin
          state_d = ST_HOLD;
          cnt_clr = 1'b1;
        end
      end
`ifdef MCU_RSTGEN_PLLWAIT_EN
      ST_PLLW: begin
        if (rst_evt) begin
          state_d = ST_HOLD;
          cnt_clr = 1'b1;
        end else if (PLL_LOCK) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
          pll_to  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_HOLD;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / status logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // HRESETn is registered from the next state, so it changes on the same
    // edge as the state and never glitches.
    hresetn_d = (state_d == ST_RUN);

    // New causes win over a simultaneous clear.
    cause_d              = cause_q;
    cause_d[2:0]         = cause_set[2:0] | (cause_q[2:0] & {3{~CAUSE_CLR}});
    // The power-on flag survives a clear issued while the system is still held.
    cause_d[CAUSE_POR]   = cause_q[CAUSE_POR] & ~(CAUSE_CLR & hresetn_q);

    // Only a fresh entry from RUN counts as a warm reset; requests that keep
    // arriving during the hold do not add more.
    warm_d = warm_q;
    if ((state_q == ST_RUN) && rst_evt && (warm_q != 8'hFF)) begin
      warm_d = warm_q + 8'd1;
    end
  end

`ifdef MCU_RSTGEN_PLLWAIT_EN
  logic pll_flag_q, pll_flag_d;

  always_comb begin
    pll_flag_d = pll_flag_q | pll_to;
  end

  always_ff @(posedge FCLK) begin
    if (PORESET) begin
      pll_flag_q <= 1'b0;
    end else begin
      pll_flag_q <= pll_flag_d;
    end
  end

  assign PLL_TIMEOUT_FLAG = pll_flag_q;
`else
  assign PLL_TIMEOUT_FLAG = 1'b0;
`endif

  assign HRESETn        = hresetn_q;
  assign RESET_CAUSE    = cause_q;
  assign WARM_RESET_CNT = warm_q;

endmodule

// File: tb/tb_mcu_rstgen.sv
// Directed bench for mcu_rstgen: reset state, release timing, cause bits,
// warm-reset counting/saturation, clear rules, and the PLL wait when built.
module tb_mcu_rstgen;

  logic       FCLK = 1'b0;
  logic       PORESET;
  logic       SYSRESETREQ;
  logic       WDOGRESETREQ;
  logic       LOCKUP;
  logic       LOCKUPRESET;
  logic       PLL_LOCK;
  logic       CAUSE_CLR;
  logic       HRESETn;
  logic [3:0] RESET_CAUSE;
  logic [7:0] WARM_RESET_CNT;
  logic       PLL_TIMEOUT_FLAG;

  int checks   = 0;
  int failures = 0;
  int n;

  // Edges from the last request edge (or last PORESET edge) until HRESETn is
  // seen high. With the PLL wait built and PLL_LOCK already high, PLLW costs
  // one extra edge.
`ifdef MCU_RSTGEN_PLLWAIT_EN
  localparam int REL = 17;
`else
  localparam int REL = 16;
`endif

  always #5 FCLK = ~FCLK;

  mcu_rstgen #(
    .RESET_CYCLES (16),
    .CNT_W        (8),
    .PLL_TIMEOUT  (1024)
  ) dut (
    .FCLK             (FCLK),
    .PORESET          (PORESET),
    .SYSRESETREQ      (SYSRESETREQ),
    .WDOGRESETREQ     (WDOGRESETREQ),
    .LOCKUP           (LOCKUP),
    .LOCKUPRESET      (LOCKUPRESET),
    .PLL_LOCK         (PLL_LOCK),
    .CAUSE_CLR        (CAUSE_CLR),
    .HRESETn          (HRESETn),
    .RESET_CAUSE      (RESET_CAUSE),
    .WARM_RESET_CNT   (WARM_RESET_CNT),
    .PLL_TIMEOUT_FLAG (PLL_TIMEOUT_FLAG)
  );

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until HRESETn is high; n is the number of edges taken (budget on expiry).
  task automatic wait_high(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((HRESETn !== 1'b1) && (cnt < budget));
  endtask

  task automatic pulse_sys();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
  endtask

  initial begin
    PORESET      = 1'b1;
    SYSRESETREQ  = 1'b0;
    WDOGRESETREQ = 1'b0;
    LOCKUP       = 1'b0;
    LOCKUPRESET  = 1'b0;
    PLL_LOCK     = 1'b1;
    CAUSE_CLR    = 1'b0;

    // Power-on reset, 5 cycles.
    repeat (5) tick();
    check("por_hresetn", HRESETn, 0);
    check("por_cause", RESET_CAUSE, 4'b1000);
    check("por_warm", WARM_RESET_CNT, 0);
    check("por_pllflag", PLL_TIMEOUT_FLAG, 0);

    PORESET = 1'b0;
    wait_high(100, n);
    check("por_release_edges", n, REL);
    check("run_cause", RESET_CAUSE, 4'b1000);
    check("run_warm", WARM_RESET_CNT, 0);

    // Single-cycle SYSRESETREQ in RUN.
    pulse_sys();
    check("sys_hresetn_next", HRESETn, 0);
    check("sys_cause", RESET_CAUSE, 4'b1001);
    check("sys_warm", WARM_RESET_CNT, 1);
    wait_high(100, n);
    check("sys_release_edges", n, REL);

    // Clear while running also drops the power-on bit.
    CAUSE_CLR = 1'b1;
    tick();
    CAUSE_CLR = 1'b0;
    check("clr_run_cause", RESET_CAUSE, 4'b0000);

    // Watchdog and qualified lockup in the same cycle: one warm reset.
    WDOGRESETREQ = 1'b1;
    LOCKUP       = 1'b1;
    LOCKUPRESET  = 1'b1;
    tick();
    WDOGRESETREQ = 1'b0;
    LOCKUP       = 1'b0;
    check("wdlk_hresetn", HRESETn, 0);
    check("wdlk_cause", RESET_CAUSE, 4'b0110);
    check("wdlk_warm", WARM_RESET_CNT, 2);
    wait_high(100, n);
    check("wdlk_release_edges", n, REL);

    // Lockup without the enable does nothing.
    LOCKUP      = 1'b1;
    LOCKUPRESET = 1'b0;
    repeat (3) tick();
    LOCKUP = 1'b0;
    check("lk_dis_hresetn", HRESETn, 1);
    check("lk_dis_cause", RESET_CAUSE, 4'b0110);
    check("lk_dis_warm", WARM_RESET_CNT, 2);

    // SYSRESETREQ held 10 cycles: counts once, release needs 16 quiet edges
    // after the request drops (26 cycles from request rise to HRESETn rise).
    SYSRESETREQ = 1'b1;
    repeat (10) tick();
    check("held_hresetn", HRESETn, 0);
    check("held_warm", WARM_RESET_CNT, 3);
    check("held_cause", RESET_CAUSE, 4'b0111);
    SYSRESETREQ = 1'b0;
    wait_high(100, n);
    check("held_release_edges", n, REL);

    // Clear, then clear together with a new watchdog cause: set wins.
    CAUSE_CLR = 1'b1;
    tick();
    check("clr2_cause", RESET_CAUSE, 4'b0000);
    WDOGRESETREQ = 1'b1;
    tick();
    WDOGRESETREQ = 1'b0;
    CAUSE_CLR    = 1'b0;
    check("clr_vs_set_cause", RESET_CAUSE, 4'b0010);
    check("clr_vs_set_warm", WARM_RESET_CNT, 4);
    wait_high(100, n);
    check("clr_vs_set_release", n, REL);

`ifdef MCU_RSTGEN_PLLWAIT_EN
    // PLL lock seen 40 cycles after the hold ends.
    PLL_LOCK = 1'b0;
    pulse_sys();
    repeat (16) tick();
    check("pllw_enter_hresetn", HRESETn, 0);
    repeat (39) tick();
    check("pllw_wait_hresetn", HRESETn, 0);
    PLL_LOCK = 1'b1;
    tick();
    check("pllw_lock_hresetn", HRESETn, 1);
    check("pllw_lock_flag", PLL_TIMEOUT_FLAG, 0);

    // PLL never locks: 16 hold edges + 1024 timeout edges.
    PLL_LOCK = 1'b0;
    pulse_sys();
    wait_high(3000, n);
    check("pll_timeout_edges", n, 1040);
    check("pll_timeout_flag", PLL_TIMEOUT_FLAG, 1);
    PLL_LOCK = 1'b1;
    pulse_sys();
    wait_high(100, n);
    check("pll_flag_sticky", PLL_TIMEOUT_FLAG, 1);
`endif

    // 300 warm resets: counter saturates.
    for (int i = 0; i < 300; i++) begin
      pulse_sys();
      wait_high(2000, n);
    end
    check("warm_saturate", WARM_RESET_CNT, 255);

    // PORESET in the middle of a hold (counter at 7).
    pulse_sys();
    repeat (7) tick();
    PORESET = 1'b1;
    tick();
    check("por_mid_hresetn", HRESETn, 0);
    check("por_mid_cause", RESET_CAUSE, 4'b1000);
    check("por_mid_warm", WARM_RESET_CNT, 0);
    check("por_mid_pllflag", PLL_TIMEOUT_FLAG, 0);

    // Clear during the hold keeps the power-on bit; full stretch still applies.
    PORESET   = 1'b0;
    CAUSE_CLR = 1'b1;
    tick();
    CAUSE_CLR = 1'b0;
    check("clr_hold_por_bit", RESET_CAUSE, 4'b1000);
    n = 1;
    while ((HRESETn !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    check("por_mid_release_edges", n, REL);

    CAUSE_CLR = 1'b1;
    tick();
    CAUSE_CLR = 1'b0;
    check("clr_run_por_bit", RESET_CAUSE, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
